// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants, types and helpers.
// Imported by the fetch unit top and its buffer.
package fetch_unit_pkg;

    localparam int          ILEN             = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ILEN-1:0] align_pc(input logic [ILEN-1:0] pc);
        return pc & ~(ILEN'(3));
    endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Synchronous FIFO with flush and simultaneous push/pop.
// Head entry is presented combinationally on rdata.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);
    assign rdata  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the buffer.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array, written at the tail on push.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC generation, one-cycle
// memory latency, redirect handling and a small instruction buffer.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out
);

    localparam int CW = $clog2(DEPTH);

    logic [31:0]   fpc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [CW:0]   count;
    logic [CW+1:0] occupancy;
    logic          pop;
    fetch_entry_t  head;
    fetch_entry_t  wentry;

    // Slots already committed once this cycle's pop retires.
    assign occupancy = {1'b0, count}
                     + {{(CW+1){1'b0}}, inflight}
                     - {{(CW+1){1'b0}}, pop};

    assign instr_valid = !reset && (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign imem_req    = !reset && !redirect_valid
                      && (occupancy < (CW+2)'(DEPTH));
    assign imem_addr   = reset ? RESET_PC : fpc;
    assign instr_out   = instr_valid ? head.instr : '0;
    assign pc_out      = instr_valid ? head.pc : '0;

    assign wentry.pc    = inflight_pc;
    assign wentry.instr = imem_rdata;

    // Fetch PC and in-flight tracking; redirect drops the pending response.
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc         <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (redirect_valid) begin
                fpc <= align_pc(redirect_pc);
            end else if (imem_req) begin
                fpc         <= fpc + PC_INC;
                inflight_pc <= fpc;
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (inflight),
        .wdata (wentry),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios then
// randomized traffic against a queue-based reference model.
module tb_fetch_unit;

    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam int          DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] pc_out;

    logic        req2;
    logic [31:0] addr2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] pc2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_out      (instr_out),
        .pc_out         (pc_out)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
        .clk            (clk),
        .reset          (rst),
        .imem_req       (req2),
        .imem_addr      (addr2),
        .imem_rdata     (32'h0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .instr_valid    (valid2),
        .instr_ready    (1'b1),
        .instr_out      (instr2),
        .pc_out         (pc2)
    );

    // Reference model state
    logic [31:0] qpc[$];
    logic [31:0] qins[$];
    logic [31:0] m_fpc;
    bit          m_inf;
    logic [31:0] m_ia;
    logic [31:0] s_pc;
    logic [31:0] salt;
    logic [31:0] resp;
    int          n_req;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a >> 2) ^ salt;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against model, advance model.
    task automatic cyc(input bit r, input bit rv, input logic [31:0] rp,
                       input bit rdy);
        bit          e_valid;
        bit          e_pop;
        bit          e_req;
        int          occ;
        logic [31:0] tgt;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        instr_ready    = rdy;
        imem_rdata     = resp;
        #1;
        e_valid = !r && (qpc.size() > 0);
        e_pop   = e_valid && rdy;
        occ     = qpc.size() + int'(m_inf) - int'(e_pop);
        e_req   = !r && !rv && (occ < DEPTH);
        chk("valid", 32'(instr_valid), 32'(e_valid));
        chk("req", 32'(imem_req), 32'(e_req));
        chk("addr", imem_addr, r ? RPC : m_fpc);
        chk("pc_out", pc_out, e_valid ? qpc[0] : 32'h0);
        chk("instr_out", instr_out, e_valid ? qins[0] : 32'h0);
        if (e_pop) begin
            chk("stream_pc", pc_out, s_pc);
            chk("stream_ins", instr_out, memf(s_pc));
            s_pc = s_pc + 32'd4;
        end
        if (imem_req) n_req++;
        resp = imem_req ? memf(imem_addr) : 32'hBAD0_BAD0;
        @(posedge clk);
        tgt = rp & 32'hFFFF_FFFC;
        if (r) begin
            qpc.delete();
            qins.delete();
            m_inf = 0;
            m_fpc = RPC;
            s_pc  = RPC;
        end else begin
            if (e_pop) begin
                void'(qpc.pop_front());
                void'(qins.pop_front());
            end
            if (rv) begin
                qpc.delete();
                qins.delete();
                m_fpc = tgt;
                m_inf = 0;
                s_pc  = tgt;
            end else begin
                if (m_inf) begin
                    qpc.push_back(m_ia);
                    qins.push_back(memf(m_ia));
                end
                if (e_req) begin
                    m_ia  = m_fpc;
                    m_fpc = m_fpc + 32'd4;
                end
                m_inf = e_req;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        instr_ready = 1'b0;
        imem_rdata = 32'h0;
        salt = 32'h0;
        resp = 32'h0;
        n_req = 0;
        m_fpc = RPC;
        m_inf = 0;
        m_ia = 32'h0;
        s_pc = RPC;
        @(negedge clk);

        // Reset state
        repeat (3) cyc(1, 0, 0, 1);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);

        // Streaming after reset release, word[i]=i
        cyc(0, 0, 0, 1);
        chk("s_addr1", imem_addr, 32'h4);
        chk("wrap_a1", addr2, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 1);
        chk("s_valid2", 32'(instr_valid), 32'h1);
        chk("s_pc2", pc_out, 32'h0);
        chk("s_ins2", instr_out, 32'h0);
        chk("wrap_a2", addr2, 32'h0);
        repeat (6) cyc(0, 0, 0, 1);

        // Stall with instr_ready low, then drain in order
        cyc(1, 0, 0, 0);
        n_req = 0;
        repeat (6) cyc(0, 0, 0, 0);
        chk("stall_reqs", 32'(n_req), 32'd2);
        chk("stall_pc", pc_out, 32'h0);
        repeat (6) cyc(0, 0, 0, 1);

        // Redirect with one buffered entry and one response in flight
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h100, 0);
        chk("rd_valid", 32'(instr_valid), 32'h0);
        chk("rd_addr", imem_addr, 32'h100);
        repeat (6) cyc(0, 0, 0, 1);

        // Redirect with a simultaneous pop, unaligned target
        cyc(0, 1, 32'h203, 1);
        chk("rdp_addr", imem_addr, 32'h200);
        repeat (4) cyc(0, 0, 0, 1);

        // Back-to-back redirects: last one wins
        cyc(0, 1, 32'h400, 1);
        cyc(0, 1, 32'h500, 1);
        chk("b2b_addr", imem_addr, 32'h500);
        repeat (5) cyc(0, 0, 0, 1);

        // Reset with a full buffer
        repeat (4) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rf_valid", 32'(instr_valid), 32'h0);
        repeat (6) cyc(0, 0, 0, 1);

        // Randomized traffic
        cyc(1, 0, 0, 1);
        salt = $urandom;
        for (int i = 0; i < 2000; i++) begin
            cyc($urandom_range(0, 99) == 0,
                $urandom_range(0, 19) == 0,
                $urandom,
                $urandom_range(0, 9) < 7);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
